bounded_step_counter: RTL and testbench

BOUNDED_STEP_COUNTER -- requirements
Module: bounded_step_counter

---
 rtl/bounded_step_counter.sv | 184 ++++++++++++++++++
 tb/tb_bounded_step_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bounded_step_counter.sv
// bounded_step_counter
//
// Up/down counter that moves by a programmable step inside an inclusive
// unsigned window [min_i, max_i]. Leaving the window is an overflow
// (upward) or underflow (downward) event, resolved by mode_i:
//   00/11 wrap      : overflow -> min_i, underflow -> max_i
//   01    saturate  : overflow -> max_i, underflow -> min_i; no event if the
//                     count already sits on that bound
//   10    one-shot  : as saturate, but every event parks the RUN/HALT
//                     machine in HALT until clr_i or load_i (with en_i)
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   en_i                 enable for clr_i / load_i / stepping
//   clr_i                count <= min_i, machine -> RUN
//   load_i, data_i       count <= data_i clamped into the window, -> RUN
//   up_i, down_i         direction request (exactly one must be high)
//   step_i               unsigned step magnitude
//   min_i, max_i         inclusive bounds (min_i > max_i freezes stepping/load)
//   mode_i               event handling mode (see above)
//   flag_clr_i           clears ovf_o/unf_o, works regardless of en_i
//   count_o              registered count
//   tc_o                 one-cycle pulse in the cycle after an event commits
//   ovf_o, unf_o         sticky event flags
//   halted_o             machine state: 1 when in HALT
//   at_max_o, at_min_o   combinational count_o == max_i / min_i
//
// Handshake: there is no valid/ready pair; every input is sampled on each
// rising clk_i edge and outputs reflect the result one cycle later.
module bounded_step_counter #(
  parameter int unsigned         WIDTH_P      = 16,
  parameter int unsigned         STEP_WIDTH_P = 8,
  parameter logic [WIDTH_P-1:0]  RESET_VAL_P  = '0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic [WIDTH_P-1:0]      data_i,
  input  logic                    up_i,
  input  logic                    down_i,
  input  logic [STEP_WIDTH_P-1:0] step_i,
  input  logic [WIDTH_P-1:0]      min_i,
  input  logic [WIDTH_P-1:0]      max_i,
  input  logic [1:0]              mode_i,
  input  logic                    flag_clr_i,
  output logic [WIDTH_P-1:0]      count_o,
  output logic                    tc_o,
  output logic                    ovf_o,
  output logic                    unf_o,
  output logic                    halted_o,
  output logic                    at_max_o,
  output logic                    at_min_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH_P-1:0]   count_q, count_d;
  logic                 tc_q, tc_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  // One extra bit so the sum never wraps and the difference carries a sign.
  logic [WIDTH_P:0]     step_ext;
  logic [WIDTH_P:0]     up_sum;
  logic [WIDTH_P:0]     dn_diff;
  logic                 ovf_hit;
  logic                 unf_hit;
  logic                 bounds_ok;
  logic                 step_go;
  logic                 mode_wrap;
  logic                 mode_sat;
  logic                 mode_oneshot;
  logic [WIDTH_P-1:0]   load_val;
  logic                 ovf_ev;
  logic                 unf_ev;

  assign step_ext     = {{(WIDTH_P + 1 - STEP_WIDTH_P){1'b0}}, step_i};
  assign up_sum       = {1'b0, count_q} + step_ext;
  assign dn_diff      = {1'b0, count_q} - step_ext;
  assign ovf_hit      = up_sum > {1'b0, max_i};
  // A set top bit means the difference went negative, which is below any min.
  assign unf_hit      = dn_diff[WIDTH_P] | (dn_diff[WIDTH_P-1:0] < min_i);
  assign bounds_ok    = (min_i <= max_i);
  assign mode_wrap    = (mode_i == 2'b00) | (mode_i == 2'b11);
  assign mode_sat     = (mode_i == 2'b01);
  assign mode_oneshot = (mode_i == 2'b10);
  assign step_go      = (up_i ^ down_i) & (state_q == ST_RUN) &
                        (step_i != '0) & bounds_ok;

  always_comb begin
    load_val = data_i;
    if (data_i < min_i) begin
      load_val = min_i;
    end else if (data_i > max_i) begin
      load_val = max_i;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;

    if (en_i) begin
      if (clr_i) begin
        count_d = min_i;
        state_d = ST_RUN;
      end else if (load_i) begin
        // An inverted window has no valid clamp target, so load is dropped.
        if (bounds_ok) begin
          count_d = load_val;
          state_d = ST_RUN;
        end
      end else if (step_go) begin
        if (up_i) begin
          if (ovf_hit) begin
            // Saturating onto a bound we already hold is not an event.
            if (!(mode_sat && (count_q == max_i))) begin
              ovf_ev  = 1'b1;
              count_d = mode_wrap ? min_i : max_i;
            end
          end else begin
            count_d = up_sum[WIDTH_P-1:0];
          end
        end else begin
          if (unf_hit) begin
            if (!(mode_sat && (count_q == min_i))) begin
              unf_ev  = 1'b1;
              count_d = mode_wrap ? max_i : min_i;
            end
          end else begin
            count_d = dn_diff[WIDTH_P-1:0];
          end
        end

        if (ovf_ev || unf_ev) begin
          tc_d = 1'b1;
          if (mode_oneshot) begin
            state_d = ST_HALT;
          end
        end
      end
    end
  end

  // Event set wins over a simultaneous flag clear.
  always_comb begin
    ovf_d = (ovf_q & ~flag_clr_i) | ovf_ev;
    unf_d = (unf_q & ~flag_clr_i) | unf_ev;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= RESET_VAL_P;
      state_q <= ST_RUN;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o  = count_q;
  assign tc_o     = tc_q;
  assign ovf_o    = ovf_q;
  assign unf_o    = unf_q;
  assign halted_o = (state_q == ST_HALT);
  assign at_max_o = (count_q == max_i);
  assign at_min_o = (count_q == min_i);

endmodule

// File: tb/tb_bounded_step_counter.sv
// Testbench for bounded_step_counter: directed scenarios for wrap, saturate,
// one-shot, priority, flags and asynchronous reset, followed by randomized
// traffic compared each cycle against an integer reference model.
module tb_bounded_step_counter;

  localparam int W  = 16;
  localparam int SW = 8;
  localparam logic [W-1:0] RST_VAL = 16'd4;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          en_i, clr_i, load_i, up_i, down_i, flag_clr_i;
  logic [W-1:0]  data_i, min_i, max_i;
  logic [SW-1:0] step_i;
  logic [1:0]    mode_i;
  logic [W-1:0]  count_o;
  logic          tc_o, ovf_o, unf_o, halted_o, at_max_o, at_min_o;

  bounded_step_counter #(
    .WIDTH_P(W), .STEP_WIDTH_P(SW), .RESET_VAL_P(RST_VAL)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .clr_i(clr_i),
    .load_i(load_i), .data_i(data_i), .up_i(up_i), .down_i(down_i),
    .step_i(step_i), .min_i(min_i), .max_i(max_i), .mode_i(mode_i),
    .flag_clr_i(flag_clr_i), .count_o(count_o), .tc_o(tc_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .halted_o(halted_o),
    .at_max_o(at_max_o), .at_min_o(at_min_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_total = 0;
  int n_bad   = 0;

  int m_count;
  bit m_tc, m_ovf, m_unf, m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = int'(RST_VAL);
    m_tc = 0; m_ovf = 0; m_unf = 0; m_halt = 0;
  endtask

  // Applies one rising edge using plain integer arithmetic on the inputs.
  task automatic model_edge();
    int lo, hi, nxt, md;
    bit ev_o, ev_u, sat;
    lo = int'(min_i); hi = int'(max_i); md = int'(mode_i);
    sat = (md == 1);
    ev_o = 0; ev_u = 0;
    if (en_i) begin
      if (clr_i) begin
        m_count = lo; m_halt = 0;
      end else if (load_i) begin
        if (lo <= hi) begin
          nxt = int'(data_i);
          if (nxt < lo) nxt = lo;
          if (nxt > hi) nxt = hi;
          m_count = nxt; m_halt = 0;
        end
      end else if ((up_i != down_i) && !m_halt && step_i != 0 && lo <= hi) begin
        if (up_i) begin
          nxt = m_count + int'(step_i);
          if (nxt <= hi) m_count = nxt;
          else if (!(sat && m_count == hi)) begin
            ev_o = 1;
            m_count = (md == 0 || md == 3) ? lo : hi;
          end
        end else begin
          nxt = m_count - int'(step_i);
          if (nxt >= lo) m_count = nxt;
          else if (!(sat && m_count == lo)) begin
            ev_u = 1;
            m_count = (md == 0 || md == 3) ? hi : lo;
          end
        end
        if ((ev_o || ev_u) && md == 2) m_halt = 1;
      end
    end
    if (flag_clr_i) begin m_ovf = 0; m_unf = 0; end
    if (ev_o) m_ovf = 1;
    if (ev_u) m_unf = 1;
    m_tc = ev_o | ev_u;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(count_o),  32'(m_count));
    chk({tag, ".tc"},     32'(tc_o),     32'(m_tc));
    chk({tag, ".ovf"},    32'(ovf_o),    32'(m_ovf));
    chk({tag, ".unf"},    32'(unf_o),    32'(m_unf));
    chk({tag, ".halted"}, 32'(halted_o), 32'(m_halt));
    chk({tag, ".at_max"}, 32'(at_max_o), 32'(m_count == int'(max_i)));
    chk({tag, ".at_min"}, 32'(at_min_o), 32'(m_count == int'(min_i)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    en_i = 0; clr_i = 0; load_i = 0; up_i = 0; down_i = 0; flag_clr_i = 0;
    data_i = '0; step_i = '0; mode_i = 2'b00;
  endtask

  task automatic set_ctl(input bit en, input bit clr, input bit ld, input bit up, input bit dn,
                         input bit fclr);
    en_i = en; clr_i = clr; load_i = ld; up_i = up; down_i = dn; flag_clr_i = fclr;
  endtask

  // Rising edge for DUT and model, then sample 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    min_i = 16'd0; max_i = 16'd100;
    model_reset();
    #12;
    chk("reset.count", 32'(count_o), 32'(RST_VAL));
    chk("reset.halted", 32'(halted_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick("idle");

    // Wrap: 2 -> 5 -> 8 -> 2 with overflow
    min_i = 16'd2; max_i = 16'd10; mode_i = 2'b00; step_i = 8'd3;
    set_ctl(1, 1, 0, 0, 0, 0); tick("wrap_clr");
    set_ctl(1, 0, 0, 1, 0, 0); tick("wrap1");
    chk("wrap1_c", 32'(count_o), 32'd5);
    tick("wrap2");
    chk("wrap2_c", 32'(count_o), 32'd8);
    tick("wrap3");
    chk("wrap3_c", 32'(count_o), 32'd2);
    chk("wrap3_tc", 32'(tc_o), 32'd1);
    chk("wrap3_ovf", 32'(ovf_o), 32'd1);
    set_ctl(1, 0, 0, 0, 0, 1); tick("wrap_fclr");

    // Saturate: 9 + 4 -> 10 with pulse, then hold silently
    min_i = 16'd0; max_i = 16'd10; mode_i = 2'b01; step_i = 8'd4; data_i = 16'd9;
    set_ctl(1, 0, 1, 0, 0, 0); tick("sat_load");
    set_ctl(1, 0, 0, 1, 0, 0); tick("sat1");
    chk("sat1_c", 32'(count_o), 32'd10);
    chk("sat1_tc", 32'(tc_o), 32'd1);
    tick("sat2");
    chk("sat2_c", 32'(count_o), 32'd10);
    chk("sat2_tc", 32'(tc_o), 32'd0);

    // One-shot: 1 - 2 -> 0, halt, hold; load 5 resumes
    mode_i = 2'b10; step_i = 8'd2; data_i = 16'd1;
    set_ctl(1, 0, 1, 0, 0, 0); tick("os_load");
    set_ctl(1, 0, 0, 0, 1, 0); tick("os1");
    chk("os1_c", 32'(count_o), 32'd0);
    chk("os1_unf", 32'(unf_o), 32'd1);
    chk("os1_halt", 32'(halted_o), 32'd1);
    set_ctl(1, 0, 0, 1, 0, 0); tick("os_hold1");
    tick("os_hold2");
    chk("os_hold_c", 32'(count_o), 32'd0);
    data_i = 16'd5;
    set_ctl(1, 0, 1, 0, 0, 0); tick("os_reload");
    chk("os_reload_c", 32'(count_o), 32'd5);
    chk("os_reload_h", 32'(halted_o), 32'd0);

    // Priority: clr beats load and up; up&down holds
    min_i = 16'd3; mode_i = 2'b00; data_i = 16'd7; step_i = 8'd1;
    set_ctl(1, 1, 1, 1, 0, 0); tick("prio1");
    chk("prio1_c", 32'(count_o), 32'd3);
    set_ctl(1, 0, 0, 1, 1, 0); tick("prio2");
    chk("prio2_c", 32'(count_o), 32'd3);

    // Flags: event beats flag_clr; flag_clr alone works with en=0
    step_i = 8'd5; min_i = 16'd3; max_i = 16'd10;
    set_ctl(1, 0, 0, 0, 1, 1); tick("flag_ev");
    chk("flag_ev_unf", 32'(unf_o), 32'd1);
    set_ctl(0, 0, 0, 0, 1, 1); tick("flag_clr");
    chk("flag_clr_unf", 32'(unf_o), 32'd0);

    // Inverted window: load ignored, clr still works
    min_i = 16'd20; max_i = 16'd10; data_i = 16'd15;
    set_ctl(1, 0, 1, 0, 0, 0); tick("inv_load");
    set_ctl(1, 0, 0, 1, 0, 0); tick("inv_step");
    set_ctl(1, 1, 0, 0, 0, 0); tick("inv_clr");
    chk("inv_clr_c", 32'(count_o), 32'd20);

    // Async reset mid-cycle with count=7 and a flag set
    min_i = 16'd0; max_i = 16'd10; mode_i = 2'b00; step_i = 8'd8; data_i = 16'd7;
    set_ctl(1, 0, 0, 1, 0, 0); tick("ar_ovf");
    set_ctl(1, 0, 1, 0, 0, 0); tick("ar_load");
    chk("ar_pre_c", 32'(count_o), 32'd7);
    #2;
    rstn_i = 1'b0;
    model_reset();
    #1;
    chk("ar.count", 32'(count_o), 32'(RST_VAL));
    chk("ar.ovf", 32'(ovf_o), 32'd0);
    chk("ar.unf", 32'(unf_o), 32'd0);
    chk("ar.tc", 32'(tc_o), 32'd0);
    chk("ar.halted", 32'(halted_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    set_ctl(1, 0, 0, 1, 0, 0); step_i = 8'd1;
    tick("ar_resume");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        min_i = 16'($urandom_range(0, 40));
        if ($urandom_range(0, 9) == 0) max_i = 16'($urandom_range(0, 40));
        else max_i = min_i + 16'($urandom_range(0, 60));
      end
      en_i       = ($urandom_range(0, 99) < 85);
      clr_i      = ($urandom_range(0, 99) < 4);
      load_i     = ($urandom_range(0, 99) < 8);
      up_i       = 1'($urandom_range(0, 1));
      down_i     = 1'($urandom_range(0, 1));
      flag_clr_i = ($urandom_range(0, 99) < 10);
      data_i     = 16'($urandom_range(0, 120));
      step_i     = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 25));
      mode_i     = 2'($urandom_range(0, 3));
      if (i == 300) begin
        #2;
        rstn_i = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk_i);
        rstn_i = 1'b1;
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
